// File: rtl/chess_game_ctrl.sv
// chess_game_ctrl: two-player chess clock controller with a tick prescaler, pause/resume, move counting and time-flag detection.
module chess_game_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int PLY_W    = 8
) (
    input  logic             clk_one,
    input  logic             reset,
    input  logic             start_pulse,
    input  logic             pause_pulse,
    input  logic             press_w,
    input  logic             press_b,
    input  logic             zero_w,
    input  logic             zero_b,
    output logic             load,
    output logic             dec_w,
    output logic             dec_b,
    output logic             inc_w,
    output logic             inc_b,
    output logic             player,
    output logic             flag_w,
    output logic             flag_b,
    output logic             running,
    output logic [PLY_W-1:0] ply_cnt,
    output logic [2:0]       state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_W  = 3'd1,
        RUN_B  = 3'd2,
        PAUSE  = 3'd3,
        FLAG_W = 3'd4,
        FLAG_B = 3'd5
    } state_t;
    localparam logic [7:0]       P_LAST  = 8'(TICK_DIV - 1);
    localparam logic [PLY_W-1:0] PLY_MAX = '1;
    state_t     st;
    logic [7:0] presc;
    logic       tick;
    logic       zero_m;
    logic       press_m;
    assign state   = st;
    assign tick    = (presc == P_LAST);
    // player always names the side to move, so it selects the mover's inputs
    assign zero_m  = player ? zero_b : zero_w;
    assign press_m = player ? press_b : press_w;
    always_ff @(posedge clk_one) begin
        if (reset) begin
            st      <= IDLE;
            load    <= 1'b1;
            dec_w   <= 1'b0;
            dec_b   <= 1'b0;
            inc_w   <= 1'b0;
            inc_b   <= 1'b0;
            player  <= 1'b0;
            flag_w  <= 1'b0;
            flag_b  <= 1'b0;
            running <= 1'b0;
            presc   <= '0;
            ply_cnt <= '0;
        end else begin
            dec_w <= 1'b0;
            dec_b <= 1'b0;
            inc_w <= 1'b0;
            inc_b <= 1'b0;
            case (st)
                IDLE: if (start_pulse) begin
                    st      <= RUN_W;
                    load    <= 1'b0;
                    running <= 1'b1;
                    player  <= 1'b0;
                    presc   <= '0;
                    ply_cnt <= '0;
                end
                RUN_W, RUN_B: begin
                    if (zero_m) begin
                        st      <= player ? FLAG_B : FLAG_W;
                        running <= 1'b0;
                        flag_w  <= ~player;
                        flag_b  <= player;
                    end else if (pause_pulse) begin
                        st      <= PAUSE;
                        running <= 1'b0;
                    end else if (press_m) begin
                        st      <= player ? RUN_W : RUN_B;
                        player  <= ~player;
                        inc_w   <= ~player;
                        inc_b   <= player;
                        presc   <= '0;
                        ply_cnt <= (ply_cnt == PLY_MAX) ? ply_cnt : ply_cnt + PLY_W'(1);
                    end else begin
                        presc <= tick ? 8'd0 : presc + 8'd1;
                        dec_w <= tick & ~player;
                        dec_b <= tick & player;
                    end
                end
                // the resume edge is itself a counting edge of the restored run
                PAUSE: if (pause_pulse) begin
                    st      <= player ? RUN_B : RUN_W;
                    running <= 1'b1;
                    presc   <= tick ? 8'd0 : presc + 8'd1;
                    dec_w   <= tick & ~player;
                    dec_b   <= tick & player;
                end
                FLAG_W, FLAG_B: if (start_pulse) begin
                    st     <= IDLE;
                    load   <= 1'b1;
                    player <= 1'b0;
                    flag_w <= 1'b0;
                    flag_b <= 1'b0;
                end
                default: begin
                    st      <= IDLE;
                    load    <= 1'b1;
                    player  <= 1'b0;
                    flag_w  <= 1'b0;
                    flag_b  <= 1'b0;
                    running <= 1'b0;
                    presc   <= '0;
                    ply_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chess_game_ctrl.sv
// tb_chess_game_ctrl: directed checks of the chess clock controller with TICK_DIV=4, PLY_W=2.
module tb_chess_game_ctrl;
    logic       clk_one = 1'b0;
    logic       reset = 1'b1;
    logic       start_pulse = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       press_w = 1'b0;
    logic       press_b = 1'b0;
    logic       zero_w = 1'b0;
    logic       zero_b = 1'b0;
    logic       load, dec_w, dec_b, inc_w, inc_b, player, flag_w, flag_b, running;
    logic [1:0] ply_cnt;
    logic [2:0] state;
    int         errors = 0;
    int         checks = 0;

    chess_game_ctrl #(.TICK_DIV(4), .PLY_W(2)) dut (
        .clk_one(clk_one), .reset(reset), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
        .press_w(press_w), .press_b(press_b), .zero_w(zero_w), .zero_b(zero_b),
        .load(load), .dec_w(dec_w), .dec_b(dec_b), .inc_w(inc_w), .inc_b(inc_b),
        .player(player), .flag_w(flag_w), .flag_b(flag_b), .running(running),
        .ply_cnt(ply_cnt), .state(state)
    );

    always #5 clk_one = ~clk_one;

    task automatic tick();
        @(posedge clk_one);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_load"}, 32'(load), 1);
        chk({tag, "_player"}, 32'(player), 0);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_flags"}, 32'({flag_w, flag_b}), 0);
        chk({tag, "_strobes"}, 32'({dec_w, dec_b, inc_w, inc_b}), 0);
        chk({tag, "_ply"}, 32'(ply_cnt), 0);
    endtask

    initial begin
        tick();
        tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();
        chk("idle_load", 32'(load), 1);
        chk("idle_state", 32'(state), 0);
        // start: first dec_w 4 edges after entering RUN_W, then every 4
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        chk("start_state", 32'(state), 1);
        chk("start_running", 32'(running), 1);
        chk("start_load", 32'(load), 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("decw_k%0d", k), 32'(dec_w), 32'(k == 4 || k == 8));
            chk($sformatf("decb_k%0d", k), 32'(dec_b), 0);
        end
        // both buttons together in RUN_W: only white's press counts
        press_w = 1'b1;
        press_b = 1'b1;
        tick();
        press_w = 1'b0;
        press_b = 1'b0;
        chk("press_state", 32'(state), 2);
        chk("press_incw", 32'(inc_w), 1);
        chk("press_incb", 32'(inc_b), 0);
        chk("press_decw", 32'(dec_w), 0);
        chk("press_ply", 32'(ply_cnt), 1);
        chk("press_player", 32'(player), 1);
        tick();
        chk("press_incw_1cyc", 32'(inc_w), 0);
        chk("press_b_ignored", 32'(state), 2);
        // black moves back to white
        press_b = 1'b1;
        tick();
        press_b = 1'b0;
        chk("pressb_state", 32'(state), 1);
        chk("pressb_incb", 32'(inc_b), 1);
        chk("pressb_ply", 32'(ply_cnt), 2);
        chk("pressb_player", 32'(player), 0);
        // two edges bring the prescaler to 2, then pause
        tick();
        tick();
        pause_pulse = 1'b1;
        tick();
        pause_pulse = 1'b0;
        chk("pause_state", 32'(state), 3);
        chk("pause_running", 32'(running), 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                press_w = 1'b1;
                zero_w = 1'b1;
                start_pulse = 1'b1;
            end
            tick();
            press_w = 1'b0;
            zero_w = 1'b0;
            start_pulse = 1'b0;
            chk($sformatf("pause_strobes_%0d", i), 32'({dec_w, dec_b, inc_w, inc_b}), 0);
            chk($sformatf("pause_hold_%0d", i), 32'(state), 3);
        end
        chk("pause_ply", 32'(ply_cnt), 2);
        pause_pulse = 1'b1;
        tick();
        pause_pulse = 1'b0;
        chk("resume_state", 32'(state), 1);
        chk("resume_running", 32'(running), 1);
        chk("resume_decw0", 32'(dec_w), 0);
        tick();
        chk("resume_decw1", 32'(dec_w), 1);
        tick();
        chk("resume_decw2", 32'(dec_w), 0);
        // presses 3..5: counter saturates at 3
        press_w = 1'b1;
        tick();
        press_w = 1'b0;
        chk("sat_ply3", 32'(ply_cnt), 3);
        press_b = 1'b1;
        tick();
        press_b = 1'b0;
        chk("sat_ply4", 32'(ply_cnt), 3);
        press_w = 1'b1;
        tick();
        press_w = 1'b0;
        chk("sat_ply5", 32'(ply_cnt), 3);
        chk("sat_state", 32'(state), 2);
        // reset while paused with black to move
        pause_pulse = 1'b1;
        tick();
        pause_pulse = 1'b0;
        chk("pause2_state", 32'(state), 3);
        chk("pause2_player", 32'(player), 1);
        reset = 1'b1;
        pause_pulse = 1'b1;
        tick();
        reset = 1'b0;
        pause_pulse = 1'b0;
        chk_reset_vals("rst_pause");
        // new game: timeout beats pause and press in RUN_B
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        press_w = 1'b1;
        tick();
        press_w = 1'b0;
        chk("g2_state", 32'(state), 2);
        chk("g2_ply", 32'(ply_cnt), 1);
        zero_b = 1'b1;
        press_b = 1'b1;
        pause_pulse = 1'b1;
        tick();
        zero_b = 1'b0;
        press_b = 1'b0;
        pause_pulse = 1'b0;
        chk("flagb_state", 32'(state), 5);
        chk("flagb_flags", 32'({flag_w, flag_b}), 1);
        chk("flagb_ply", 32'(ply_cnt), 1);
        chk("flagb_running", 32'(running), 0);
        chk("flagb_incb", 32'(inc_b), 0);
        press_w = 1'b1;
        tick();
        press_w = 1'b0;
        press_b = 1'b1;
        tick();
        press_b = 1'b0;
        chk("flagb_hold", 32'(state), 5);
        chk("flagb_hold_ply", 32'(ply_cnt), 1);
        chk("flagb_strobes", 32'({dec_w, dec_b, inc_w, inc_b}), 0);
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        chk("flagb_exit_state", 32'(state), 0);
        chk("flagb_exit_load", 32'(load), 1);
        chk("flagb_exit_flag", 32'(flag_b), 0);
        // white timeout
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        zero_w = 1'b1;
        tick();
        zero_w = 1'b0;
        chk("flagw_state", 32'(state), 4);
        chk("flagw_flags", 32'({flag_w, flag_b}), 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
